ilog2_pipe: RTL and testbench



---
 rtl/ilog2_pipe.sv | 153 +++++++++++++++
 tb/tb_ilog2_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ilog2_pipe.sv
// ilog2_pipe: fully pipelined floor(log2) unit with a valid/ready handshake,
// a zero flag and an in-order sideband tag. One input register stage is
// followed by LOG_W bisection stages, so the latency is LOG_W+1 cycles. All
// stages advance together whenever the output slot is empty or being consumed.
// Optional feature macro: ILOG2_FRAC_EN adds out_frac, the FRAC_W bits
// directly below the leading one of the operand.
module ilog2_pipe #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 8,
   parameter int LOG_W  = $clog2(DATA_W),
   parameter int FRAC_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LOG_W-1:0]  out_log2,
   output logic              out_zero,
   output logic [TAG_W-1:0]  out_tag
`ifdef ILOG2_FRAC_EN
   ,
   output logic [FRAC_W-1:0] out_frac
`endif
);

   // Reject parameter values the bisection scheme cannot handle
   if (DATA_W < 8 || DATA_W > 64 || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_data_w
      $error("ilog2_pipe: DATA_W must be a power of two in 8..64");
   end
   if (TAG_W < 1) begin : g_bad_tag_w
      $error("ilog2_pipe: TAG_W must be at least 1");
   end
   if (FRAC_W < 1 || FRAC_W > 8) begin : g_bad_frac_w
      $error("ilog2_pipe: FRAC_W must be in 1..8");
   end

   // Stage 0 is the input register; stage j (1..LOG_W) resolves result bit LOG_W-j.
   logic              vld_q  [0:LOG_W];
   logic              vld_d  [0:LOG_W];
   logic [DATA_W-1:0] win_q  [0:LOG_W];
   logic [DATA_W-1:0] win_d  [0:LOG_W];
   logic [LOG_W-1:0]  res_q  [0:LOG_W];
   logic [LOG_W-1:0]  res_d  [0:LOG_W];
   logic              zero_q [0:LOG_W];
   logic              zero_d [0:LOG_W];
   logic [TAG_W-1:0]  tag_q  [0:LOG_W];
   logic [TAG_W-1:0]  tag_d  [0:LOG_W];

   logic adv;

   assign adv      = ~vld_q[LOG_W] | out_ready;
   assign in_ready = adv & ~reset;

   assign out_valid = vld_q[LOG_W];
   assign out_log2  = res_q[LOG_W];
   assign out_zero  = zero_q[LOG_W];
   assign out_tag   = tag_q[LOG_W];

   // Next state: load the operand, then halve the window once per stage
   always_comb begin
      int   half;
      logic nz;
      half   = 0;
      nz     = 1'b0;
      vld_d  = vld_q;
      win_d  = win_q;
      res_d  = res_q;
      zero_d = zero_q;
      tag_d  = tag_q;
      if (adv) begin
         vld_d[0]  = in_valid;
         win_d[0]  = in_data;
         res_d[0]  = '0;
         zero_d[0] = (in_data == '0);
         tag_d[0]  = in_tag;
         for (int j = 1; j <= LOG_W; j++) begin
            // Window entering stage j is 2*half bits wide; test its upper half.
            half      = 1 << (LOG_W - j);
            nz        = ((win_q[j-1] >> half) != '0);
            vld_d[j]  = vld_q[j-1];
            zero_d[j] = zero_q[j-1];
            tag_d[j]  = tag_q[j-1];
            res_d[j]  = res_q[j-1] | (LOG_W'(nz) << (LOG_W - j));
            win_d[j]  = nz ? (win_q[j-1] >> half)
                           : (win_q[j-1] & ((DATA_W'(1) << half) - DATA_W'(1)));
         end
      end
   end

   // Stage registers: synchronous reset clears every stage, otherwise load next state
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int j = 0; j <= LOG_W; j++) begin
            vld_q[j]  <= 1'b0;
            win_q[j]  <= '0;
            res_q[j]  <= '0;
            zero_q[j] <= 1'b0;
            tag_q[j]  <= '0;
         end
      end else begin
         vld_q  <= vld_d;
         win_q  <= win_d;
         res_q  <= res_d;
         zero_q <= zero_d;
         tag_q  <= tag_d;
      end
   end

`ifdef ILOG2_FRAC_EN
   // The original operand rides along so the final stage can normalise it
   // against the completed exponent.
   logic [DATA_W-1:0] val_q [0:LOG_W-1];
   logic [DATA_W-1:0] val_d [0:LOG_W-1];
   logic [FRAC_W-1:0] frac_q;
   logic [FRAC_W-1:0] frac_d;
   logic [LOG_W-1:0]  shamt;

   assign out_frac = frac_q;

   // Next state: carry operand, then left-justify it and take the bits under the leading one
   always_comb begin
      val_d  = val_q;
      frac_d = frac_q;
      shamt  = LOG_W'(DATA_W - 1) - res_d[LOG_W];
      if (adv) begin
         val_d[0] = in_data;
         for (int j = 1; j < LOG_W; j++) begin
            val_d[j] = val_q[j-1];
         end
         // Appending FRAC_W zeros gives the zero-fill when few bits sit below the leading one.
         frac_d = FRAC_W'(({val_q[LOG_W-1], {FRAC_W{1'b0}}} << shamt) >> (DATA_W - 1));
      end
   end

   // Fraction registers share the pipeline's reset and advance
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int j = 0; j < LOG_W; j++) begin
            val_q[j] <= '0;
         end
         frac_q <= '0;
      end else begin
         val_q  <= val_d;
         frac_q <= frac_d;
      end
   end
`endif

endmodule

// File: tb/tb_ilog2_pipe.sv
// Bench for ilog2_pipe: a 32-bit instance driven cycle by cycle against an
// age-based queue model, plus 8-bit and 64-bit instances for latency/width.
module tb_ilog2_pipe;

   localparam int L32 = 6;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // 32-bit instance
   logic        in_valid, in_ready, out_valid, out_ready, out_zero;
   logic [31:0] in_data;
   logic [7:0]  in_tag, out_tag;
   logic [4:0]  out_log2;
`ifdef ILOG2_FRAC_EN
   logic [3:0]  out_frac;
`endif

   ilog2_pipe #(.DATA_W(32), .TAG_W(8), .FRAC_W(4)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_log2(out_log2),
      .out_zero(out_zero), .out_tag(out_tag)
`ifdef ILOG2_FRAC_EN
      , .out_frac(out_frac)
`endif
   );

   // 8-bit instance
   logic       a8_in_valid, a8_in_ready, a8_out_valid, a8_out_ready, a8_out_zero;
   logic [7:0] a8_in_data, a8_in_tag, a8_out_tag;
   logic [2:0] a8_out_log2;
`ifdef ILOG2_FRAC_EN
   logic [3:0] a8_out_frac;
`endif

   ilog2_pipe #(.DATA_W(8), .TAG_W(8), .FRAC_W(4)) dut8 (
      .clk(clk), .reset(reset),
      .in_valid(a8_in_valid), .in_ready(a8_in_ready), .in_data(a8_in_data), .in_tag(a8_in_tag),
      .out_valid(a8_out_valid), .out_ready(a8_out_ready), .out_log2(a8_out_log2),
      .out_zero(a8_out_zero), .out_tag(a8_out_tag)
`ifdef ILOG2_FRAC_EN
      , .out_frac(a8_out_frac)
`endif
   );

   // 64-bit instance
   logic        a64_in_valid, a64_in_ready, a64_out_valid, a64_out_ready, a64_out_zero;
   logic [63:0] a64_in_data;
   logic [7:0]  a64_in_tag, a64_out_tag;
   logic [5:0]  a64_out_log2;
`ifdef ILOG2_FRAC_EN
   logic [3:0]  a64_out_frac;
`endif

   ilog2_pipe #(.DATA_W(64), .TAG_W(8), .FRAC_W(4)) dut64 (
      .clk(clk), .reset(reset),
      .in_valid(a64_in_valid), .in_ready(a64_in_ready), .in_data(a64_in_data), .in_tag(a64_in_tag),
      .out_valid(a64_out_valid), .out_ready(a64_out_ready), .out_log2(a64_out_log2),
      .out_zero(a64_out_zero), .out_tag(a64_out_tag)
`ifdef ILOG2_FRAC_EN
      , .out_frac(a64_out_frac)
`endif
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Model: each accepted operand with the number of advancing edges it has seen.
   typedef struct {
      logic [31:0] v;
      logic [7:0]  tag;
      int          age;
   } ent_t;
   ent_t q[$];

   logic       prev_stall = 1'b0;
   logic [4:0] prev_log2;
   logic [7:0] prev_tag;
   logic       prev_zero;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", name, obs, exp);
      end
   endtask

   function automatic int ref_log2(input logic [63:0] v);
      int l = 0;
      for (int b = 0; b < 64; b++) if (v[b]) l = b;
      return l;
   endfunction

   function automatic logic [3:0] ref_frac(input logic [63:0] v);
      logic [127:0] t;
      t = ({64'd0, v} << 4) >> ref_log2(v);
      return t[3:0];
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         default: return $urandom >> $urandom_range(0, 31);
      endcase
   endfunction

   // One clock cycle: entered 1 time unit after a rising edge with inputs driven.
   task automatic tick();
      logic exp_v, exp_adv;
      #1;
      exp_v   = (q.size() > 0) && (q[0].age == L32);
      exp_adv = !exp_v || out_ready;
      check("in_ready", in_ready, exp_adv && !reset);
      check("out_valid", out_valid, exp_v);
      if (exp_v) begin
         check("out_log2", out_log2, ref_log2(q[0].v));
         check("out_zero", out_zero, q[0].v == 0);
         check("out_tag", out_tag, q[0].tag);
`ifdef ILOG2_FRAC_EN
         check("out_frac", out_frac, ref_frac(q[0].v));
`endif
      end
      if (prev_stall) begin
         check("stall_log2", out_log2, prev_log2);
         check("stall_tag", out_tag, prev_tag);
         check("stall_zero", out_zero, prev_zero);
      end
      prev_stall = out_valid && !out_ready;
      prev_log2  = out_log2;
      prev_tag   = out_tag;
      prev_zero  = out_zero;
      @(posedge clk);
      if (reset) begin
         q.delete();
         prev_stall = 1'b0;
      end else if (exp_adv) begin
         if (exp_v) void'(q.pop_front());
         for (int i = 0; i < q.size(); i++) q[i].age++;
         if (in_valid) q.push_back('{v: in_data, tag: in_tag, age: 1});
      end
      #1;
   endtask

   task automatic drive(input logic vld, input logic [31:0] v, input logic [7:0] tag,
                        input logic ordy);
      in_valid  = vld;
      in_data   = v;
      in_tag    = tag;
      out_ready = ordy;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, guard, lat;
      logic vok;
      reset = 1'b1;
      in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
      a8_in_valid = 1'b0; a8_in_data = '0; a8_in_tag = '0; a8_out_ready = 1'b1;
      a64_in_valid = 1'b0; a64_in_data = '0; a64_in_tag = '0; a64_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_log2", out_log2, 0);
      check("rst_out_zero", out_zero, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_in_ready", in_ready, 0);
      reset = 1'b0;

      // Back-to-back directed operands, zero operand, fraction operands
      drive(1, 32'd1, 8'd1, 1);
      drive(1, 32'd2, 8'd2, 1);
      drive(1, 32'd3, 8'd3, 1);
      drive(1, 32'h8000_0000, 8'd4, 1);
      drive(1, 32'hFFFF_FFFF, 8'd5, 1);
      drive(1, 32'd0, 8'hAA, 1);
      drive(1, 32'd176, 8'h10, 1);
      drive(1, 32'd3, 8'h11, 1);
      drive(1, 32'd1, 8'h12, 1);
      repeat (8) drive(0, 32'd0, 8'd0, 1);

      // Random stream with random backpressure
      acc = 0;
      guard = 0;
      while (acc < 20 && guard < 400) begin
         vok       = ($urandom_range(0, 3) != 0);
         in_valid  = vok;
         in_data   = rand_operand();
         in_tag    = 8'(acc) + 8'h40;
         out_ready = 1'($urandom_range(0, 1));
         if (vok && (!((q.size() > 0) && (q[0].age == L32)) || out_ready)) acc++;
         tick();
         guard++;
      end
      check("stream_accepted", acc, 20);
      guard = 0;
      while (q.size() > 0 && guard < 40) begin
         drive(0, 32'd0, 8'd0, 1'($urandom_range(0, 1)));
         guard++;
      end
      check("stream_drained", q.size(), 0);

      // Fill the pipe, reset mid-stream, then restart
      for (int i = 0; i < 6; i++) drive(1, 32'd1 << (i * 5), 8'h60 + 8'(i), 1);
      reset = 1'b1;
      drive(0, 32'd0, 8'd0, 1);
      reset = 1'b0;
      check("post_rst_valid", out_valid, 0);
      check("post_rst_log2", out_log2, 0);
      check("post_rst_zero", out_zero, 0);
      check("post_rst_tag", out_tag, 0);
      drive(1, 32'd256, 8'h77, 1);
      repeat (9) drive(0, 32'd0, 8'd0, 1);

      // 8-bit instance: 0x80 -> 7 with latency 4
      a8_in_valid = 1'b1; a8_in_data = 8'h80; a8_in_tag = 8'h5A;
      #1;
      check("a8_in_ready", a8_in_ready, 1);
      @(posedge clk); #1;
      a8_in_valid = 1'b0;
      lat = 1;
      while (!a8_out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("a8_latency", lat, 4);
      check("a8_log2", a8_out_log2, 7);
      check("a8_zero", a8_out_zero, 0);
      check("a8_tag", a8_out_tag, 8'h5A);

      // 64-bit instance: 2^40 -> 40 with latency 7
      a64_in_valid = 1'b1; a64_in_data = 64'd1 << 40; a64_in_tag = 8'hC3;
      #1;
      check("a64_in_ready", a64_in_ready, 1);
      @(posedge clk); #1;
      a64_in_valid = 1'b0;
      lat = 1;
      while (!a64_out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("a64_latency", lat, 7);
      check("a64_log2", a64_out_log2, 40);
      check("a64_zero", a64_out_zero, 0);
      check("a64_tag", a64_out_tag, 8'hC3);
`ifdef ILOG2_FRAC_EN
      check("a64_frac", a64_out_frac, 4'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
